// File: rtl/video_out.sv
// 640x480@60 raster generator with a small pixel FIFO feeding hdmi_video.
// VIDEO_OUT_UNDERFLOW_MAGENTA_EN: when defined, starved active pixels show magenta instead of black.
module video_out #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int PIX_DIV    = 2,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic [23:0] pix_data_i,
   input  logic        pix_valid_i,
   output logic        pix_ready_o,
   output logic        frame_start_o,
   input  logic        underflow_clr_i,
   output logic        underflow_o,
   output logic [9:0]  line_o,
   output logic        hsync_n_o,
   output logic        vsync_n_o,
   output logic        blank_n_o,
   output logic [23:0] vga_color_o
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam int AW      = $clog2(FIFO_DEPTH);

   localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
   localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0]    HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]    HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]    VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]    VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

`ifdef VIDEO_OUT_UNDERFLOW_MAGENTA_EN
   localparam logic [23:0] UF_COLOR = 24'hFF00FF;
`else
   localparam logic [23:0] UF_COLOR = 24'h000000;
`endif

   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic [9:0]    h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [23:0]   mem_q [FIFO_DEPTH];
   logic [23:0]   mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ready_q, ready_d;
   logic          frame_start_q, frame_start_d;
   logic          underflow_q, underflow_d;
   logic          hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d, blank_n_q, blank_n_d;
   logic [9:0]    line_q, line_d;
   logic [23:0]   color_q, color_d;

   logic pix_tick, active, fifo_empty, push, pop, flush, uf_set;

   assign pix_tick   = (div_cnt_q == DIV_LAST);
   assign active     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
   assign fifo_empty = (count_q == '0);
   assign push       = pix_valid_i && ready_q;
   assign pop        = pix_tick && active && !fifo_empty;
   // Flush one line ahead of the first visible line so the fetcher restarts aligned.
   assign flush      = pix_tick && (h_cnt_q == '0) && (v_cnt_q == V_LAST);
   assign uf_set     = pix_tick && active && fifo_empty;

   always_comb begin
      div_cnt_d = pix_tick ? '0 : div_cnt_q + 1'b1;
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      if (pix_tick) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
         end else begin
            h_cnt_d = h_cnt_q + 10'd1;
         end
      end
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = pix_data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_d = count_q + 1'b1;
         end else if (!push && pop) begin
            count_d = count_q - 1'b1;
         end
      end
      ready_d       = (count_d != FULL_CNT);
      frame_start_d = flush;
      underflow_d   = uf_set ? 1'b1 : (underflow_clr_i ? 1'b0 : underflow_q);
   end

   always_comb begin
      hsync_n_d = hsync_n_q;
      vsync_n_d = vsync_n_q;
      blank_n_d = blank_n_q;
      line_d    = line_q;
      color_d   = color_q;
      if (pix_tick) begin
         hsync_n_d = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
         vsync_n_d = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
         blank_n_d = active;
         line_d    = v_cnt_q;
         if (!active) begin
            color_d = '0;
         end else if (fifo_empty) begin
            color_d = UF_COLOR;
         end else begin
            color_d = mem_q[rd_ptr_q];
         end
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q     <= '0;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         mem_q         <= '{default: '0};
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         ready_q       <= 1'b0;
         frame_start_q <= 1'b0;
         underflow_q   <= 1'b0;
         hsync_n_q     <= 1'b1;
         vsync_n_q     <= 1'b1;
         blank_n_q     <= 1'b0;
         line_q        <= '0;
         color_q       <= '0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         mem_q         <= mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         ready_q       <= ready_d;
         frame_start_q <= frame_start_d;
         underflow_q   <= underflow_d;
         hsync_n_q     <= hsync_n_d;
         vsync_n_q     <= vsync_n_d;
         blank_n_q     <= blank_n_d;
         line_q        <= line_d;
         color_q       <= color_d;
      end
   end

   assign pix_ready_o   = ready_q;
   assign frame_start_o = frame_start_q;
   assign underflow_o   = underflow_q;
   assign line_o        = line_q;
   assign hsync_n_o     = hsync_n_q;
   assign vsync_n_o     = vsync_n_q;
   assign blank_n_o     = blank_n_q;
   assign vga_color_o   = color_q;
endmodule

// File: tb/tb_video_out.sv
// Bench for video_out on a shrunken raster: a queue-based reference model predicts every
// output cycle, a monitor compares, and directed checks cover reset, flush and underflow.
module tb_video_out;
   localparam int HA = 16, HFP = 2, HSW = 4, HBP = 3;
   localparam int VA = 6, VFP = 1, VSW = 2, VBP = 2;
   localparam int PD = 2, DEPTH = 8;
   localparam int HT = HA + HFP + HSW + HBP;
   localparam int VT = VA + VFP + VSW + VBP;
   localparam int FRAME_CYC = HT * VT * PD;
   localparam int BIG = 1 << 30;
   localparam logic [39:0] RESET_VEC = {1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 24'd0};
`ifdef VIDEO_OUT_UNDERFLOW_MAGENTA_EN
   localparam logic [23:0] UF = 24'hFF00FF;
`else
   localparam logic [23:0] UF = 24'h000000;
`endif

   logic        clk_sys = 1'b0;
   logic        rst_n = 1'b1;
   logic [23:0] pix_data_i = '0;
   logic        pix_valid_i = 1'b0;
   logic        underflow_clr_i = 1'b0;
   logic        pix_ready_o, frame_start_o, underflow_o;
   logic [9:0]  line_o;
   logic        hsync_n_o, vsync_n_o, blank_n_o;
   logic [23:0] vga_color_o;

   video_out #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .PIX_DIV(PD), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk_sys(clk_sys), .rst_n(rst_n),
      .pix_data_i(pix_data_i), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
      .frame_start_o(frame_start_o), .underflow_clr_i(underflow_clr_i),
      .underflow_o(underflow_o), .line_o(line_o), .hsync_n_o(hsync_n_o),
      .vsync_n_o(vsync_n_o), .blank_n_o(blank_n_o), .vga_color_o(vga_color_o)
   );

   always #5 clk_sys = ~clk_sys;

   int n_checks = 0;
   int n_errors = 0;
   logic [39:0] exp_q[$];

   // Reference model: raster position as a tick index, pixel FIFO as a queue.
   int          m_phase, m_pos;
   logic [23:0] m_fq[$];
   logic        m_ready, m_uf, m_fs, m_hs, m_vs, m_blank;
   logic [9:0]  m_line;
   logic [23:0] m_col;
   int          src_cnt = 0;

   function automatic logic [39:0] dut_vec();
      return {pix_ready_o, frame_start_o, underflow_o, line_o, hsync_n_o, vsync_n_o, blank_n_o, vga_color_o};
   endfunction

   function automatic logic flush_next();
      return (m_phase == PD - 1) && (m_pos == (VT - 1) * HT);
   endfunction

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_step();
      int h, v;
      logic tick, active, push, flush, setf;
      if (!rst_n) begin
         m_phase = 0; m_pos = 0; m_fq.delete();
         m_ready = 0; m_uf = 0; m_fs = 0;
         m_hs = 1; m_vs = 1; m_blank = 0; m_line = '0; m_col = '0;
      end else begin
         h      = m_pos % HT;
         v      = m_pos / HT;
         tick   = (m_phase == PD - 1);
         active = (h < HA) && (v < VA);
         push   = pix_valid_i && m_ready;
         flush  = tick && (h == 0) && (v == VT - 1);
         setf   = tick && active && (m_fq.size() == 0);
         if (tick) begin
            m_hs    = !((h >= HA + HFP) && (h < HA + HFP + HSW));
            m_vs    = !((v >= VA + VFP) && (v < VA + VFP + VSW));
            m_blank = active;
            m_line  = 10'(v);
            if (!active) m_col = '0;
            else if (m_fq.size() == 0) m_col = UF;
            else m_col = m_fq.pop_front();
         end
         if (flush) m_fq.delete();
         else if (push) m_fq.push_back(pix_data_i);
         m_ready = (m_fq.size() < DEPTH);
         m_uf    = setf ? 1'b1 : (underflow_clr_i ? 1'b0 : m_uf);
         m_fs    = flush;
         m_phase = tick ? 0 : m_phase + 1;
         if (tick) m_pos = (m_pos + 1) % (HT * VT);
      end
      exp_q.push_back({m_ready, m_fs, m_uf, m_line, m_hs, m_vs, m_blank, m_col});
   endtask

   // Inputs are set before calling; the model predicts the upcoming edge.
   task automatic cycle();
      model_step();
      @(negedge clk_sys);
   endtask

   task automatic src_cycle(input int limit);
      logic acc;
      if (frame_start_o) src_cnt = 0;
      pix_valid_i = (src_cnt < limit);
      pix_data_i  = 24'(src_cnt);
      acc = pix_valid_i && pix_ready_o;
      cycle();
      if (acc) src_cnt++;
   endtask

   task automatic wait_fs(input int limit);
      int i;
      for (i = 0; i < 2 * FRAME_CYC && !frame_start_o; i++) src_cycle(limit);
      chk("frame_start_seen", 40'(frame_start_o), 40'd1);
   endtask

   task automatic run_to_pos(input int pos, input int limit);
      for (int i = 0; i < 2 * FRAME_CYC && m_pos != pos; i++) src_cycle(limit);
   endtask

   task automatic flush_test(input int fill, input logic [23:0] first_px);
      int pushed = 0;
      logic acc;
      run_to_pos(VA * HT, 0);
      for (int i = 0; i < FRAME_CYC && !flush_next(); i++) begin
         pix_valid_i = (pushed < fill);
         pix_data_i  = 24'($urandom);
         acc = pix_valid_i && pix_ready_o;
         cycle();
         if (acc) pushed++;
      end
      pix_valid_i = 1'b1;
      pix_data_i  = 24'hBAD0BA;
      cycle();
      chk("flush_pulse", 40'(frame_start_o), 40'd1);
      chk("flush_empty_ready", 40'(pix_ready_o), 40'd1);
      pix_data_i = first_px;
      cycle();
      chk("pulse_width", 40'(frame_start_o), 40'd0);
      pix_valid_i = 1'b0;
      for (int i = 0; i < FRAME_CYC && !blank_n_o; i++) cycle();
      chk("pixel00_after_flush", 40'(vga_color_o), 40'(first_px));
   endtask

   always @(posedge clk_sys) begin
      logic [39:0] exp;
      #1;
      if (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         chk("outputs", dut_vec(), exp);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst_n = 1'b0;
      #1 chk("reset_values", dut_vec(), RESET_VEC);
      @(negedge clk_sys);
      repeat (2) cycle();
      rst_n = 1'b1;
      cycle();
      chk("ready_after_reset", 40'(pix_ready_o), 40'd1);

      // Idle source for two frames: pure timing, frame 0 underflows.
      repeat (2 * FRAME_CYC) src_cycle(0);
      chk("idle_underflow", 40'(underflow_o), 40'd1);

      // Ideal source restarted on every frame_start_o.
      wait_fs(BIG);
      underflow_clr_i = 1'b1;
      src_cycle(BIG);
      underflow_clr_i = 1'b0;
      repeat (3 * FRAME_CYC) src_cycle(BIG);
      chk("stream_no_underflow", 40'(underflow_o), 40'd0);

      // Starve after 10 beats of line 0, then resume on the next frame.
      wait_fs(BIG);
      run_to_pos(VA * HT, 10);
      chk("starve_underflow", 40'(underflow_o), 40'd1);
      wait_fs(0);
      underflow_clr_i = 1'b1;
      src_cycle(BIG);
      underflow_clr_i = 1'b0;
      run_to_pos(VA * HT, BIG);
      chk("resume_clean", 40'(underflow_o), 40'd0);

      flush_test(DEPTH, 24'h123456);
      flush_test(DEPTH - 2, 24'h654321);

      // Asynchronous reset in the middle of line 4.
      run_to_pos(4 * HT + 7, BIG);
      rst_n = 1'b0;
      pix_valid_i = 1'b0;
      #1 chk("async_reset_mid", dut_vec(), RESET_VEC);
      repeat (3) cycle();
      rst_n = 1'b1;
      cycle();
      chk("ready_after_mid_reset", 40'(pix_ready_o), 40'd1);

      // Clear coinciding with an underflowing tick, then a clear in blanking.
      for (int i = 0; i < FRAME_CYC; i++) begin
         if ((m_phase == PD - 1) && (m_pos % HT < HA) && (m_pos / HT < VA) && (m_fq.size() == 0)) break;
         cycle();
      end
      underflow_clr_i = 1'b1;
      cycle();
      underflow_clr_i = 1'b0;
      chk("set_beats_clear", 40'(underflow_o), 40'd1);
      run_to_pos(VA * HT, 0);
      underflow_clr_i = 1'b1;
      cycle();
      underflow_clr_i = 1'b0;
      chk("clear_in_blank", 40'(underflow_o), 40'd0);

      // Random source with backpressure and sporadic clears.
      repeat (2 * FRAME_CYC) begin
         pix_valid_i     = 1'($urandom_range(0, 1));
         pix_data_i      = 24'($urandom);
         underflow_clr_i = ($urandom_range(0, 31) == 0);
         cycle();
      end
      pix_valid_i     = 1'b0;
      underflow_clr_i = 1'b0;
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/video_out.md
# video_out

Video timing and pixel output stage for the ULX3S build. Runs in `clk_sys`, generates 640x480@60 raster timing on a pixel-enable tick, and drains a small pixel FIFO fed by the framebuffer fetcher over a valid/ready stream. It produces the active-low sync/blank signals and the 24-bit colour consumed directly by `hdmi_video`.

## Interface
**Parameters**
- `H_ACTIVE` = 640: visible pixels per line
- `H_FP` = 16: horizontal front porch, in pixels
- `H_SYNC` = 96: horizontal sync width, in pixels
- `H_BP` = 48: horizontal back porch, in pixels
- `V_ACTIVE` = 480: visible lines
- `V_FP` = 10: vertical front porch, in lines
- `V_SYNC` = 2: vertical sync width, in lines
- `V_BP` = 33: vertical back porch, in lines
- `PIX_DIV` = 2: `clk_sys` cycles per pixel, ≥1 (50 MHz / 2 = 25 MHz)
- `FIFO_DEPTH` = 16: pixel FIFO entries, power of two

**Ports**
- `clk_sys` in 1: system clock; the only clock
- `rst_n` in 1: asynchronous active-low reset
- `pix_data_i` in 24: pixel colour, RGB888
- `pix_valid_i` in 1: pixel beat valid
- `pix_ready_o` out 1: FIFO can accept a beat
- `frame_start_o` out 1: one-cycle pulse telling the fetcher to restart at pixel (0,0)
- `underflow_clr_i` in 1: clears `underflow_o`
- `underflow_o` out 1: sticky flag, FIFO was empty on an active pixel
- `line_o` out 10: current `v_cnt`
- `hsync_n_o` out 1: horizontal sync, active low
- `vsync_n_o` out 1: vertical sync, active low
- `blank_n_o` out 1: high during active video
- `vga_color_o` out 24: pixel colour; 0 while blanked

## Operation
- **Pixel tick.** `div_cnt` counts 0..`PIX_DIV-1`. `pix_tick` is high when `div_cnt == PIX_DIV-1`. If `PIX_DIV` = 1, `pix_tick` is always high.
- **Raster counters.** `h_cnt` runs 0..H_TOTAL-1 (800) and `v_cnt` runs 0..V_TOTAL-1 (525). Both advance only on `pix_tick`. `h_cnt` wraps to 0 and increments `v_cnt` at the same time. `v_cnt` wraps 524→0.
- **Raster decode.**
  - active = `h_cnt < H_ACTIVE && v_cnt < V_ACTIVE`
  - hsync is asserted for `h_cnt` in [656, 752)
  - vsync is asserted for `v_cnt` in [490, 492)
- **FIFO.**
  - A beat is pushed when `pix_valid_i && pix_ready_o`.
  - A beat is popped on `pix_tick` when active and the FIFO is not empty.
  - Push and pop in the same cycle leave the count unchanged.
  - `pix_ready_o` is registered and equals `!full` of the next-cycle count. It is never high while the FIFO is full.
- **Underflow.** On an active `pix_tick` with the FIFO empty:
  - no pop occurs;
  - the output colour is the underflow colour (see Configuration);
  - `underflow_o` is set.
  - `underflow_clr_i` clears `underflow_o`. If a set and a clear occur in the same cycle, the set wins.
- **Frame restart.** On the `pix_tick` with `h_cnt == 0 && v_cnt == V_TOTAL-1` (one line before the first active line):
  - the FIFO is flushed (count = 0);
  - `frame_start_o` is asserted for exactly the following `clk_sys` cycle;
  - a beat presented on the flush edge is dropped;
  - beats accepted while `frame_start_o` is high are kept as the first pixels of the new frame.

  This flush re-aligns the fetcher after any underflow or overrun.
- **Reset mid-frame.**
  - Counters, `div_cnt` and the FIFO clear immediately.
  - The raster restarts at (0,0) without a `frame_start_o` pulse.
  - Frame 0 after reset therefore underflows. This is expected.

## Timing
- **Reset values:**
  - `hsync_n_o` = 1, `vsync_n_o` = 1, `blank_n_o` = 0
  - `vga_color_o` = 0, `pix_ready_o` = 0, `frame_start_o` = 0, `underflow_o` = 0, `line_o` = 0
- `pix_ready_o` rises in the first cycle after `rst_n` deasserts.
- All video outputs are registered and update only on `pix_tick`. Each output reflects the counter state sampled at that tick, 1 `clk_sys` cycle later.
- The sync, blank and colour outputs are always mutually aligned.
- A pixel pushed while the FIFO is empty can be displayed at the next active `pix_tick` at the earliest, i.e. at least 1 cycle after the push.
- `line_o` updates together with `blank_n_o`.

## Configuration
- The macro `VIDEO_OUT_UNDERFLOW_MAGENTA_EN` selects the underflow colour.
  - **Defined:** the underflow colour is 24'hFF00FF, so starvation is visible on screen.
  - **Undefined:** the underflow colour is 24'h000000.
- `underflow_o` behaves identically in both builds.

## Test plan
- **Timing.** Hold `pix_valid_i` = 0 for 2 frames.
  - Required: period of 800 ticks/line and 525 lines/frame (840000 `clk_sys` cycles at `PIX_DIV` = 2).
  - Required: `hsync_n_o` low for 96 ticks starting at `h_cnt` 656; `vsync_n_o` low on lines 490–491.
  - Required: `blank_n_o` high for 640×480 ticks per frame; `underflow_o` = 1.
- **Streaming.** An ideal source, always valid, supplies an incrementing colour restarted on `frame_start_o`.
  - Required: pixel (x,y) shows colour y*640+x.
  - Required: `underflow_o` stays 0 over 3 frames; `pix_ready_o` never high when 16 entries are held.
- **Starvation.** Stop the source after 100 beats of line 0.
  - Required: `underflow_o` = 1.
  - Required: pixels 100..639 show 24'hFF00FF when `VIDEO_OUT_UNDERFLOW_MAGENTA_EN` is defined, otherwise 0.
  - Required: after the next `frame_start_o`, resuming the source gives a clean frame.
- **Flush.** Fill the FIFO to 16 during vertical blank.
  - Required: count is 0 after the flush tick.
  - Required: `frame_start_o` is a single 1-cycle pulse.
  - Required: a beat offered on the flush edge is dropped; the beat accepted during the pulse is pixel (0,0).
- **Reset mid-operation.** Assert `rst_n` = 0 at line 200, pixel 300, for 3 cycles.
  - Required: all outputs take their reset values asynchronously.
  - Required: the raster restarts at (0,0); `pix_ready_o` returns to 1 one cycle after release.
- **Clear vs set.** Pulse `underflow_clr_i` in the same cycle as an underflowing tick.
  - Required: `underflow_o` remains 1.
  - Required: a clear during blanking returns it to 0.
